// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file, one write port, two registered
// read ports with optional write bypass, hardwired r0 and tri-state outputs.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   wr_en/addr/data synchronous write port
//   rda_* / rdb_*   read ports: en+addr in, registered data+valid out
//   written         per-entry flag, set by a write since the last reset
module regfile_2r1w #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 5,
    parameter int BYPASS       = 1,
    parameter int R0_ZERO      = 0,
    parameter int TRISTATE_OUT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rda_en,
    input  logic [ADDR_W-1:0]        rda_addr,
    output logic [DATA_W-1:0]        rda_data,
    output logic                     rda_valid,
    input  logic                     rdb_en,
    input  logic [ADDR_W-1:0]        rdb_addr,
    output logic [DATA_W-1:0]        rdb_data,
    output logic                     rdb_valid,
    output logic [(1<<ADDR_W)-1:0]   written
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rda_q;
    logic [DATA_W-1:0] rdb_q;
    logic [DATA_W-1:0] rda_next;
    logic [DATA_W-1:0] rdb_next;
    logic              wr_hit;

    // A write to r0 is dropped entirely when r0 is hardwired to zero.
    assign wr_hit = wr_en && !((R0_ZERO != 0) && (wr_addr == '0));

    always_comb begin
        rda_next = mem[rda_addr];
        if ((R0_ZERO != 0) && (rda_addr == '0))
            rda_next = '0;
        else if ((BYPASS != 0) && wr_hit && (wr_addr == rda_addr))
            rda_next = wr_data;
    end

    always_comb begin
        rdb_next = mem[rdb_addr];
        if ((R0_ZERO != 0) && (rdb_addr == '0))
            rdb_next = '0;
        else if ((BYPASS != 0) && wr_hit && (wr_addr == rdb_addr))
            rdb_next = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            written <= '0;
        end else if (wr_hit) begin
            mem[wr_addr]     <= wr_data;
            written[wr_addr] <= 1'b1;
        end
    end

    // Data registers are zeroed whenever no read is pending so the value
    // is held for the valid cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rda_valid <= 1'b0;
            rdb_valid <= 1'b0;
            rda_q     <= '0;
            rdb_q     <= '0;
        end else begin
            rda_valid <= rda_en;
            rdb_valid <= rdb_en;
            rda_q     <= rda_en ? rda_next : '0;
            rdb_q     <= rdb_en ? rdb_next : '0;
        end
    end

    // Release the bus while idle so the port can share the operand bus.
    assign rda_data = ((TRISTATE_OUT != 0) && !rda_valid) ? {DATA_W{1'bz}} : rda_q;
    assign rdb_data = ((TRISTATE_OUT != 0) && !rdb_valid) ? {DATA_W{1'bz}} : rdb_q;

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised register file; successor to the single 8-bit read/write register cell used on the datapath bus.
- One synchronous write port and two independent registered read ports, full-depth address decoding, and synchronous clear.
- Optional write-to-read bypass, optional hardwired-zero register 0, and optional tri-state read outputs so a port can drive the shared data bus directly.
- Sits between the instruction decoder (addresses, enables) and the ALU operand bus.

Parameters:
- DATA_W, 8: width of each register in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W (default 32 entries).
- BYPASS, 1: 1 = a read of the address written in the same cycle returns the new data; 0 = returns the old data.
- R0_ZERO, 0: 1 = register 0 always reads 0 and writes to it are dropped.
- TRISTATE_OUT, 1: 1 = read data is high-Z while its valid is low; 0 = read data is 0 while its valid is low.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rda_en  input  1  port A read request.
- rda_addr  input  ADDR_W  port A read address.
- rda_data  output  DATA_W  port A read data (registered).
- rda_valid  output  1  port A data valid.
- rdb_en  input  1  port B read request.
- rdb_addr  input  ADDR_W  port B read address.
- rdb_data  output  DATA_W  port B read data (registered).
- rdb_valid  output  1  port B data valid.
- written  output  2**ADDR_W  per-entry flag: entry written since reset.

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous, active-high on rst, sampled at the rising edge of clk.
- Reset: on a clk edge with rst=1:
  - all entries clear to 0;
  - written clears to all 0;
  - rda_valid and rdb_valid go to 0;
  - rda_data and rdb_data go to Z (TRISTATE_OUT=1) or 0 (TRISTATE_OUT=0).
  - rst overrides any wr_en or rd_en presented in that cycle.
- Write: on a clk edge with wr_en=1 and rst=0:
  - mem[wr_addr] <= wr_data;
  - written[wr_addr] <= 1.
  - If R0_ZERO=1 and wr_addr=0, the write is dropped and written[0] stays 0.
- Read latency: exactly 1 cycle, and each port is independent.
  - A request presented at edge N (rdX_en=1) gives rdX_valid=1 and rdX_data=value during cycle N+1.
  - With rdX_en=0 at edge N, rdX_valid=0 in cycle N+1 and data is Z or 0 per TRISTATE_OUT.
  - Back-to-back requests give continuous valid.
  - Read data holds only for the single valid cycle.
- Read value selection, in priority order:
  1. R0_ZERO=1 and addr=0 -> 0.
  2. BYPASS=1, wr_en=1 (not dropped by R0_ZERO), wr_addr=rdX_addr at the same edge -> wr_data.
  3. Otherwise -> mem[addr] contents before the edge.
- Same address on both ports: both ports return identical data.
- Writing the same address on consecutive cycles: last write wins. A read issued one cycle after a write always sees the new value, regardless of BYPASS.
- Addresses are always in range (depth = 2**ADDR_W); no wrap handling is needed.
- Reset mid-read: a request at the same edge as rst=1 is discarded; valid is 0 in the following cycle.

Test Plan:
- Reset check: write 0x5A to entries 0..31, assert rst one cycle, then read all entries on both ports -> every rdX_data = 0x00, written = 0, and rdX_valid = 0 in the cycle right after rst.
- Basic write/read: write 0x3C to addr 7, then read addr 7 on A the next cycle -> rda_valid=1 and rda_data=0x3C one cycle later; written[7]=1.
- Bypass: mem[9]=0x11, same edge wr_en=1 addr 9 data 0xAA and rda_en=1 addr 9.
  - BYPASS=1 -> rda_data=0xAA.
  - BYPASS=0 -> rda_data=0x11; a repeat read the next cycle -> 0xAA.
- Dual-port: write addr 3=0x01 and addr 4=0x02; read A=3 and B=4 in the same cycle -> 0x01 and 0x02; then A=B=4 -> both 0x02.
- R0_ZERO=1: write 0xFF to addr 0, then read addr 0 -> 0x00 and written[0]=0. With R0_ZERO=0, the same sequence reads 0xFF.
- Output idle and reset mid-read:
  - With rda_en=0 -> rda_valid=0 and rda_data=Z (TRISTATE_OUT=1) or 0x00 (TRISTATE_OUT=0).
  - rda_en=1 together with rst=1 -> rda_valid=0 in the next cycle.
